ecc_jacobian_point_unit: RTL and testbench



---
 rtl/ecc_jacobian_point_unit_pkg.sv | 63 ++++++
 rtl/ecc_jacobian_point_unit_if.sv | 17 +
 rtl/ecc_jacobian_point_unit_modmul.sv | 61 ++++++
 rtl/ecc_jacobian_point_unit.sv | 156 +++++++++++++++
 tb/tb_ecc_jacobian_point_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ecc_jacobian_point_unit_pkg.sv
// Shared types, register-file map and micro-programs for the Jacobian point unit.
// Micro-op fields: opcode, source A, source B, destination register index.
package ecc_pkg;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_MUL, S_ALU, S_DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_ADD, OP_SUB} opcode_t;
    typedef logic [3:0] ridx_t;

    typedef struct packed {
        opcode_t op;
        ridx_t   src_a;
        ridx_t   src_b;
        ridx_t   dst;
    } uop_t;

    localparam int unsigned NREGS        = 12;
    localparam int unsigned PROG_LEN     = 23;
    localparam int unsigned ADD_CHECK_PC = 9;

    localparam ridx_t R_X1 = 4'd0,  R_Y1 = 4'd1,  R_Z1 = 4'd2;
    localparam ridx_t R_X2 = 4'd3,  R_Y2 = 4'd4,  R_Z2 = 4'd5;
    localparam ridx_t R_T0 = 4'd6,  R_T1 = 4'd7,  R_T2 = 4'd8;
    localparam ridx_t R_T3 = 4'd9,  R_T4 = 4'd10, R_T5 = 4'd11;
    // Read-only alias for the latched curve coefficient a
    localparam ridx_t R_A  = 4'd12;
    localparam ridx_t R_X3 = R_T1,  R_Y3 = R_T5,  R_Z3 = R_T0;

    // H lands in T3 and R in T4; X1/Y1/Z1 stay intact so doubling can restart
    localparam uop_t ADD_PROG [PROG_LEN] = '{
        '{OP_MUL, R_Z2, R_Z2, R_T0}, '{OP_MUL, R_X1, R_T0, R_T1},
        '{OP_MUL, R_T0, R_Z2, R_T0}, '{OP_MUL, R_Y1, R_T0, R_T2},
        '{OP_MUL, R_Z1, R_Z1, R_T0}, '{OP_MUL, R_X2, R_T0, R_T3},
        '{OP_MUL, R_T0, R_Z1, R_T0}, '{OP_MUL, R_Y2, R_T0, R_T4},
        '{OP_SUB, R_T3, R_T1, R_T3}, '{OP_SUB, R_T4, R_T2, R_T4},
        '{OP_MUL, R_T3, R_T3, R_T0}, '{OP_MUL, R_T1, R_T0, R_T5},
        '{OP_MUL, R_T0, R_T3, R_T0}, '{OP_MUL, R_T4, R_T4, R_T1},
        '{OP_SUB, R_T1, R_T0, R_T1}, '{OP_MUL, R_T2, R_T0, R_T2},
        '{OP_SUB, R_T1, R_T5, R_T1}, '{OP_SUB, R_T1, R_T5, R_T1},
        '{OP_SUB, R_T5, R_T1, R_T5}, '{OP_MUL, R_T4, R_T5, R_T5},
        '{OP_SUB, R_T5, R_T2, R_T5}, '{OP_MUL, R_Z1, R_Z2, R_T0},
        '{OP_MUL, R_T0, R_T3, R_T0}
    };

    localparam uop_t DBL_PROG [PROG_LEN] = '{
        '{OP_MUL, R_Y1, R_Y1, R_T0}, '{OP_MUL, R_X1, R_T0, R_T2},
        '{OP_ADD, R_T2, R_T2, R_T2}, '{OP_ADD, R_T2, R_T2, R_T2},
        '{OP_MUL, R_X1, R_X1, R_T3}, '{OP_ADD, R_T3, R_T3, R_T4},
        '{OP_ADD, R_T4, R_T3, R_T3}, '{OP_MUL, R_Z1, R_Z1, R_T4},
        '{OP_MUL, R_T4, R_T4, R_T4}, '{OP_MUL, R_A,  R_T4, R_T4},
        '{OP_ADD, R_T3, R_T4, R_T3}, '{OP_MUL, R_T3, R_T3, R_T1},
        '{OP_SUB, R_T1, R_T2, R_T1}, '{OP_SUB, R_T1, R_T2, R_T1},
        '{OP_SUB, R_T2, R_T1, R_T4}, '{OP_MUL, R_T3, R_T4, R_T4},
        '{OP_MUL, R_T0, R_T0, R_T0}, '{OP_ADD, R_T0, R_T0, R_T0},
        '{OP_ADD, R_T0, R_T0, R_T0}, '{OP_ADD, R_T0, R_T0, R_T0},
        '{OP_SUB, R_T4, R_T0, R_T5}, '{OP_MUL, R_Y1, R_Z1, R_T0},
        '{OP_ADD, R_T0, R_T0, R_T0}
    };

    function automatic state_t exec_state(opcode_t op);
        return (op == OP_MUL) ? S_MUL : S_ALU;
    endfunction

endpackage

// File: rtl/ecc_jacobian_point_unit_if.sv
// Operand/result handshake bundle between the scalar-mult controller and the point unit.
interface ecc_jacobian_point_unit_if #(parameter int unsigned WIDTH = 256);
    logic             i_valid, o_ready, i_mode;
    logic [WIDTH-1:0] i_p, i_a;
    logic [WIDTH-1:0] i_x1, i_y1, i_z1, i_x2, i_y2, i_z2;
    logic             o_valid, i_ready, o_inf;
    logic [WIDTH-1:0] o_x3, o_y3, o_z3;

    modport master (
        output i_valid, i_mode, i_p, i_a, i_x1, i_y1, i_z1, i_x2, i_y2, i_z2, i_ready,
        input  o_ready, o_valid, o_x3, o_y3, o_z3, o_inf
    );
    modport slave (
        input  i_valid, i_mode, i_p, i_a, i_x1, i_y1, i_z1, i_x2, i_y2, i_z2, i_ready,
        output o_ready, o_valid, o_x3, o_y3, o_z3, o_inf
    );
endinterface

// File: rtl/ecc_jacobian_point_unit_modmul.sv
// Bit-serial MSB-first interleaved modular multiplier, ready pulses WIDTH+2 cycles after start.
module ecc_modmul #(parameter int unsigned WIDTH = 256) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_p,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_r
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_r, b_r, p_r, acc, acc_n, dbl_red;
    logic [WIDTH:0]   dbl, dbl_m, sum, sum_m;
    logic [CW-1:0]    cnt;
    logic             busy;

    // Borrow bit of (x - p) selects between x and x - p
    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_m   = dbl - {1'b0, p_r};
        dbl_red = dbl_m[WIDTH] ? dbl[WIDTH-1:0] : dbl_m[WIDTH-1:0];
        sum     = {1'b0, dbl_red} + (a_r[WIDTH-1] ? {1'b0, b_r} : '0);
        sum_m   = sum - {1'b0, p_r};
        acc_n   = sum_m[WIDTH] ? sum[WIDTH-1:0] : sum_m[WIDTH-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy    <= 1'b0;
            o_ready <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            p_r     <= '0;
        end else begin
            o_ready <= 1'b0;
            if (i_start) begin
                a_r  <= i_a;
                b_r  <= i_b;
                p_r  <= i_p;
                acc  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (cnt == CW'(WIDTH)) begin
                    busy    <= 1'b0;
                    o_ready <= 1'b1;
                end else begin
                    acc <= acc_n;
                    a_r <= {a_r[WIDTH-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign o_r = acc;
endmodule

// File: rtl/ecc_jacobian_point_unit.sv
// Jacobian point add/double over GF(p): micro-sequenced over one modmul and a 1-cycle add/sub.
module ecc_jacobian_point_unit
    import ecc_pkg::*;
#(parameter int unsigned WIDTH = 256) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    ecc_jacobian_point_unit_if.slave bus
);
    state_t           state, state_n;
    logic [WIDTH-1:0] rf [NREGS];
    logic [WIDTH-1:0] p_r, a_r, x3_r, y3_r, z3_r;
    logic             mode_r, dbl_r, issued, z1z, z2z, y1z, inf_r;
    logic [4:0]       pc, pc_inc;
    uop_t             cur_op;
    opcode_t          nxt_opc;
    logic [WIDTH-1:0] opa, opb, alu_res, mul_res, wdata;
    logic [WIDTH-1:0] fin_x, fin_y, fin_z, sc_x, sc_y, sc_z;
    logic [WIDTH:0]   sum_w, sum_m, dif_w;
    logic             accept, mul_start, mul_ready, op_done, ld_sc, ld_fin, start_prog, restart;

    assign accept    = (state == S_IDLE) && bus.i_valid;
    assign mul_start = (state == S_MUL) && !issued;
    assign op_done   = (state == S_ALU) || ((state == S_MUL) && issued && mul_ready);

    always_comb begin
        cur_op  = dbl_r ? DBL_PROG[pc] : ADD_PROG[pc];
        pc_inc  = (pc == 5'(PROG_LEN - 1)) ? '0 : pc + 5'd1;
        nxt_opc = dbl_r ? DBL_PROG[pc_inc].op : ADD_PROG[pc_inc].op;
        opa     = (cur_op.src_a == R_A) ? a_r : rf[cur_op.src_a];
        opb     = (cur_op.src_b == R_A) ? a_r : rf[cur_op.src_b];
        sum_w   = {1'b0, opa} + {1'b0, opb};
        sum_m   = sum_w - {1'b0, p_r};
        dif_w   = {1'b0, opa} - {1'b0, opb};
        if (cur_op.op == OP_SUB)
            alu_res = dif_w[WIDTH] ? dif_w[WIDTH-1:0] + p_r : dif_w[WIDTH-1:0];
        else
            alu_res = sum_m[WIDTH] ? sum_w[WIDTH-1:0] : sum_m[WIDTH-1:0];
        wdata = (state == S_MUL) ? mul_res : alu_res;
        // Final op may be writing a result register on the same edge
        fin_x = (cur_op.dst == R_X3) ? wdata : rf[R_X3];
        fin_y = (cur_op.dst == R_Y3) ? wdata : rf[R_Y3];
        fin_z = (cur_op.dst == R_Z3) ? wdata : rf[R_Z3];
    end

    always_comb begin
        state_n    = state;
        ld_sc      = 1'b0;
        ld_fin     = 1'b0;
        start_prog = 1'b0;
        restart    = 1'b0;
        sc_x       = WIDTH'(1);
        sc_y       = WIDTH'(1);
        sc_z       = '0;
        case (state)
            S_IDLE:  if (bus.i_valid) state_n = S_LOAD;
            S_LOAD:  state_n = S_CHECK;
            S_CHECK: begin
                if (!mode_r && (z1z != z2z)) begin
                    ld_sc = 1'b1;
                    sc_x  = z1z ? rf[R_X2] : rf[R_X1];
                    sc_y  = z1z ? rf[R_Y2] : rf[R_Y1];
                    sc_z  = z1z ? rf[R_Z2] : rf[R_Z1];
                end else if (z1z || (mode_r && y1z)) begin
                    ld_sc = 1'b1;
                end else begin
                    start_prog = 1'b1;
                    state_n    = exec_state(mode_r ? DBL_PROG[0].op : ADD_PROG[0].op);
                end
                if (ld_sc) state_n = S_DONE;
            end
            S_MUL, S_ALU: begin
                if (op_done) begin
                    // H == 0 after forming R: equal points double, opposite points give infinity
                    if ((state == S_ALU) && !dbl_r && (pc == 5'(ADD_CHECK_PC)) && (rf[R_T3] == '0)) begin
                        if (alu_res == '0) begin
                            restart = 1'b1;
                            state_n = exec_state(DBL_PROG[0].op);
                        end else begin
                            ld_sc   = 1'b1;
                            state_n = S_DONE;
                        end
                    end else if (pc == 5'(PROG_LEN - 1)) begin
                        ld_fin  = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        state_n = exec_state(nxt_opc);
                    end
                end
            end
            S_DONE:  if (bus.i_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x3_r <= '0; y3_r <= '0; z3_r <= '0; inf_r <= 1'b0;
            p_r <= '0; a_r <= '0; mode_r <= 1'b0; dbl_r <= 1'b0;
            issued <= 1'b0; pc <= '0; z1z <= 1'b0; z2z <= 1'b0; y1z <= 1'b0;
        end else begin
            if (accept) begin
                rf[R_X1] <= bus.i_x1; rf[R_Y1] <= bus.i_y1; rf[R_Z1] <= bus.i_z1;
                rf[R_X2] <= bus.i_x2; rf[R_Y2] <= bus.i_y2; rf[R_Z2] <= bus.i_z2;
                p_r <= bus.i_p; a_r <= bus.i_a; mode_r <= bus.i_mode;
            end
            if (state == S_LOAD) begin
                z1z <= (rf[R_Z1] == '0);
                z2z <= (rf[R_Z2] == '0);
                y1z <= (rf[R_Y1] == '0);
            end
            if (start_prog) begin
                pc    <= '0;
                dbl_r <= mode_r;
            end
            if (mul_start) issued <= 1'b1;
            if (op_done) begin
                rf[cur_op.dst] <= wdata;
                issued         <= 1'b0;
                pc             <= pc_inc;
            end
            if (restart) begin
                pc    <= '0;
                dbl_r <= 1'b1;
            end
            if (ld_sc) begin
                x3_r <= sc_x; y3_r <= sc_y; z3_r <= sc_z; inf_r <= (sc_z == '0);
            end
            if (ld_fin) begin
                x3_r <= fin_x; y3_r <= fin_y; z3_r <= fin_z; inf_r <= (fin_z == '0);
            end
        end
    end

    ecc_modmul #(.WIDTH(WIDTH)) u_modmul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (mul_start),
        .i_a     (opa),
        .i_b     (opb),
        .i_p     (p_r),
        .o_ready (mul_ready),
        .o_r     (mul_res)
    );

    assign bus.o_ready = (state == S_IDLE);
    assign bus.o_valid = (state == S_DONE);
    assign bus.o_x3    = x3_r;
    assign bus.o_y3    = y3_r;
    assign bus.o_z3    = z3_r;
    assign bus.o_inf   = inf_r;
endmodule

// File: tb/tb_ecc_jacobian_point_unit.sv
// Directed bench for the Jacobian point unit on y^2 = x^3 + 2x + 2 over GF(17), G = (5,1).
module tb_ecc_jacobian_point_unit;
    localparam int TIMEOUT = 400;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic stable;

    ecc_jacobian_point_unit_if #(.WIDTH(8)) bus ();

    ecc_jacobian_point_unit #(.WIDTH(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int inv17(input int v);
        for (int i = 1; i < 17; i++)
            if (((v * i) % 17) == 1) return i;
        return 0;
    endfunction

    function automatic int aff_x(input int x, input int z);
        int zi = inv17(z);
        return (x * zi * zi) % 17;
    endfunction

    function automatic int aff_y(input int y, input int z);
        int zi = inv17(z);
        return (y * zi * zi * zi) % 17;
    endfunction

    task automatic drive_ops(input logic mode, input logic [7:0] x1, y1, z1, x2, y2, z2);
        bus.i_mode = mode; bus.i_p = 8'd17; bus.i_a = 8'd2;
        bus.i_x1 = x1; bus.i_y1 = y1; bus.i_z1 = z1;
        bus.i_x2 = x2; bus.i_y2 = y2; bus.i_z2 = z2;
        bus.i_valid = 1'b1;
    endtask

    task automatic scramble_ops(input logic mode);
        bus.i_valid = 1'b0; bus.i_mode = ~mode; bus.i_p = '0; bus.i_a = '0;
        bus.i_x1 = '0; bus.i_y1 = '0; bus.i_z1 = '0;
        bus.i_x2 = '0; bus.i_y2 = '0; bus.i_z2 = '0;
    endtask

    // Returns the number of clock edges from the accept edge to the first o_valid
    task automatic run_op(input logic mode, input logic [7:0] x1, y1, z1, x2, y2, z2,
                          output int latency);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.o_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        drive_ops(mode, x1, y1, z1, x2, y2, z2);
        @(posedge clk); #1;
        scramble_ops(mode);
        latency = 1;
        while (!bus.o_valid && latency < TIMEOUT) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_ready = 1'b0;
        scramble_ops(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_o_valid", int'(bus.o_valid), 0);
        chk("reset_o_ready", int'(bus.o_ready), 1);
        chk("reset_o_x3", int'(bus.o_x3), 0);
        chk("reset_o_z3", int'(bus.o_z3), 0);
        chk("reset_o_inf", int'(bus.o_inf), 0);
        @(negedge clk);
        rst = 1'b0;

        // G + 2G = 3G = (10,6)
        run_op(1'b0, 8'd5, 8'd1, 8'd1, 8'd6, 8'd3, 8'd1, lat);
        chk("add_latency", lat, 186);
        chk("add_x", aff_x(int'(bus.o_x3), int'(bus.o_z3)), 10);
        chk("add_y", aff_y(int'(bus.o_y3), int'(bus.o_z3)), 6);
        chk("add_inf", int'(bus.o_inf), 0);
        release_result();

        // G + 2G with 2G given as (3,13,3)
        run_op(1'b0, 8'd5, 8'd1, 8'd1, 8'd3, 8'd13, 8'd3, lat);
        chk("add_z3_x", aff_x(int'(bus.o_x3), int'(bus.o_z3)), 10);
        chk("add_z3_y", aff_y(int'(bus.o_y3), int'(bus.o_z3)), 6);
        release_result();

        // 2G = (6,3)
        run_op(1'b1, 8'd5, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, lat);
        chk("dbl_latency", lat, 126);
        chk("dbl_x", aff_x(int'(bus.o_x3), int'(bus.o_z3)), 6);
        chk("dbl_y", aff_y(int'(bus.o_y3), int'(bus.o_z3)), 3);
        release_result();

        // Double G given as (3,8,2)
        run_op(1'b1, 8'd3, 8'd8, 8'd2, 8'd0, 8'd0, 8'd0, lat);
        chk("dbl_z2_x", aff_x(int'(bus.o_x3), int'(bus.o_z3)), 6);
        chk("dbl_z2_y", aff_y(int'(bus.o_y3), int'(bus.o_z3)), 3);
        release_result();

        // G + G in add mode takes the doubling path
        run_op(1'b0, 8'd5, 8'd1, 8'd1, 8'd5, 8'd1, 8'd1, lat);
        chk("degen_latency", lat, 3 + 8 * 11 + 2 + 10 * 11 + 13);
        chk("degen_x", aff_x(int'(bus.o_x3), int'(bus.o_z3)), 6);
        chk("degen_y", aff_y(int'(bus.o_y3), int'(bus.o_z3)), 3);
        release_result();

        // G + (-G) = infinity
        run_op(1'b0, 8'd5, 8'd1, 8'd1, 8'd5, 8'd16, 8'd1, lat);
        chk("neg_latency", lat, 3 + 8 * 11 + 2);
        chk("neg_inf", int'(bus.o_inf), 1);
        chk("neg_z3", int'(bus.o_z3), 0);
        chk("neg_x3", int'(bus.o_x3), 1);
        chk("neg_y3", int'(bus.o_y3), 1);
        release_result();

        // P at infinity: Q returned unmodified
        run_op(1'b0, 8'd9, 8'd9, 8'd0, 8'd6, 8'd3, 8'd1, lat);
        chk("z1_latency", lat, 3);
        chk("z1_x3", int'(bus.o_x3), 6);
        chk("z1_y3", int'(bus.o_y3), 3);
        chk("z1_z3", int'(bus.o_z3), 1);
        chk("z1_inf", int'(bus.o_inf), 0);
        release_result();

        // Q at infinity: P returned
        run_op(1'b0, 8'd3, 8'd8, 8'd2, 8'd7, 8'd7, 8'd0, lat);
        chk("z2_latency", lat, 3);
        chk("z2_x3", int'(bus.o_x3), 3);
        chk("z2_y3", int'(bus.o_y3), 8);
        chk("z2_z3", int'(bus.o_z3), 2);
        release_result();

        // Both at infinity
        run_op(1'b0, 8'd3, 8'd8, 8'd0, 8'd7, 8'd7, 8'd0, lat);
        chk("zz_x3", int'(bus.o_x3), 1);
        chk("zz_z3", int'(bus.o_z3), 0);
        chk("zz_inf", int'(bus.o_inf), 1);
        release_result();

        // Doubling a point with y = 0
        run_op(1'b1, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, lat);
        chk("dbl_y0_latency", lat, 3);
        chk("dbl_y0_y3", int'(bus.o_y3), 1);
        chk("dbl_y0_inf", int'(bus.o_inf), 1);
        release_result();

        // Stall at DONE for 20 cycles
        run_op(1'b0, 8'd5, 8'd1, 8'd1, 8'd6, 8'd3, 8'd1, lat);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.o_valid || bus.o_ready ||
                aff_x(int'(bus.o_x3), int'(bus.o_z3)) != 10 ||
                aff_y(int'(bus.o_y3), int'(bus.o_z3)) != 6)
                stable = 1'b0;
        end
        chk("stall_stable", int'(stable), 1);
        release_result();

        // Reset in the middle of an add
        @(negedge clk);
        drive_ops(1'b0, 8'd5, 8'd1, 8'd1, 8'd6, 8'd3, 8'd1);
        @(posedge clk); #1;
        scramble_ops(1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_o_valid", int'(bus.o_valid), 0);
        chk("midrst_o_ready", int'(bus.o_ready), 1);
        chk("midrst_o_x3", int'(bus.o_x3), 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b0, 8'd5, 8'd1, 8'd1, 8'd6, 8'd3, 8'd1, lat);
        chk("post_rst_latency", lat, 186);
        chk("post_rst_x", aff_x(int'(bus.o_x3), int'(bus.o_z3)), 10);
        chk("post_rst_y", aff_y(int'(bus.o_y3), int'(bus.o_z3)), 6);
        release_result();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
